// File: rtl/lc3_control.sv
// Multicycle LC-3 control FSM: sequences fetch/decode/execute, drives the datapath
// control inputs combinationally from the current state and IR, and keeps the NZP
// condition codes sampled from the bus.
module lc3_control #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [15:0] bus,
  output logic        ld_ir,
  output logic        ld_reg,
  output logic        ld_pc,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [1:0]  aluk,
  output logic        a1m_sel,
  output logic [1:0]  a2m_sel,
  output logic [1:0]  pcmux_sel,
  output logic        marmux_sel,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        gate_alu,
  output logic        gate_pc,
  output logic        gate_marmux,
  output logic        gate_mdr,
  output logic [2:0]  nzp,
  output logic        instr_done,
  output logic        halted
);

  typedef enum logic [3:0] {
    OP_BR, OP_ADD, OP_LD, OP_ST, OP_JSR, OP_AND, OP_LDR, OP_STR,
    OP_RTI, OP_NOT, OP_LDI, OP_STI, OP_JMP, OP_RES, OP_LEA, OP_TRAP
  } opcode_e;

  typedef enum logic [4:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_EXEC,
    S_ADDR, S_RD1, S_IND, S_RD2, S_WB, S_SMDR, S_WR,
    S_TRAP1, S_TRAP2, S_TRAP_RD, S_TRAP3, S_HALT
  } state_e;

  // Fetch reads hold MEM_WAIT cycles; data reads get one extra leading cycle so the
  // freshly loaded MAR settles before memory is sampled.
  localparam logic [4:0] FETCH_LAST = 5'(MEM_WAIT - 1);
  localparam logic [4:0] DATA_LAST  = 5'(MEM_WAIT);

  state_e     state;
  logic [4:0] wcnt;
  opcode_e    op;
  logic       cc_load;
  logic       unused_ir;

  assign op        = opcode_e'(ir[15:12]);
  assign unused_ir = ^ir[5:3];

  // State sequencing, memory wait counting and condition-code capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH1;
      wcnt  <= '0;
      nzp   <= 3'b010;
    end else begin
      if (cc_load) begin
        if (bus[15])         nzp <= 3'b100;
        else if (bus == '0)  nzp <= 3'b010;
        else                 nzp <= 3'b001;
      end
      case (state)
        S_FETCH1: state <= S_FETCH2;
        S_FETCH2: begin
          if (wcnt == FETCH_LAST) begin
            wcnt  <= '0;
            state <= S_FETCH3;
          end else begin
            wcnt <= wcnt + 5'd1;
          end
        end
        S_FETCH3: state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_JSR, OP_LEA: state <= S_EXEC;
            OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI:           state <= S_ADDR;
            OP_TRAP:                                                state <= S_TRAP1;
            default:                                                state <= S_HALT;
          endcase
        end
        S_EXEC: state <= S_FETCH1;
        S_ADDR: state <= (op == OP_ST || op == OP_STR) ? S_SMDR : S_RD1;
        S_RD1: begin
          if (wcnt == DATA_LAST) begin
            wcnt  <= '0;
            state <= (op == OP_LDI || op == OP_STI) ? S_IND : S_WB;
          end else begin
            wcnt <= wcnt + 5'd1;
          end
        end
        S_IND: state <= (op == OP_LDI) ? S_RD2 : S_SMDR;
        S_RD2: begin
          if (wcnt == DATA_LAST) begin
            wcnt  <= '0;
            state <= S_WB;
          end else begin
            wcnt <= wcnt + 5'd1;
          end
        end
        S_WB:    state <= S_FETCH1;
        S_SMDR:  state <= S_WR;
        S_WR:    state <= S_FETCH1;
        S_TRAP1: state <= S_TRAP2;
        S_TRAP2: state <= S_TRAP_RD;
        S_TRAP_RD: begin
          if (wcnt == DATA_LAST) begin
            wcnt  <= '0;
            state <= S_TRAP3;
          end else begin
            wcnt <= wcnt + 5'd1;
          end
        end
        S_TRAP3: state <= S_FETCH1;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH1;
      endcase
    end
  end

  // Control outputs decoded from the current state and the instruction register.
  always_comb begin
    ld_ir = 1'b0; ld_reg = 1'b0; ld_pc = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0;
    dr = '0; sr1 = '0; sr2 = '0; aluk = '0;
    a1m_sel = 1'b0; a2m_sel = '0; pcmux_sel = '0; marmux_sel = 1'b0;
    mem_en = 1'b0; mem_rw = 1'b0;
    gate_alu = 1'b0; gate_pc = 1'b0; gate_marmux = 1'b0; gate_mdr = 1'b0;
    instr_done = 1'b0; halted = 1'b0;

    if (state != S_FETCH1 && state != S_FETCH2 && state != S_FETCH3 && state != S_HALT) begin
      dr  = (op == OP_JSR || op == OP_TRAP) ? 3'd7 : ir[11:9];
      sr1 = ir[8:6];
      sr2 = ir[2:0];
    end

    case (state)
      S_FETCH1: begin
        gate_pc = 1'b1; ld_mar = 1'b1; pcmux_sel = 2'd2; ld_pc = 1'b1;
      end
      S_FETCH2: begin
        mem_en = 1'b1;
        ld_mdr = (wcnt == FETCH_LAST);
      end
      S_FETCH3: begin
        gate_mdr = 1'b1; ld_ir = 1'b1;
      end
      S_EXEC: begin
        instr_done = 1'b1;
        case (op)
          OP_ADD: begin aluk = 2'b10; gate_alu = 1'b1; ld_reg = 1'b1; end
          OP_AND: begin aluk = 2'b01; gate_alu = 1'b1; ld_reg = 1'b1; end
          OP_NOT: begin aluk = 2'b11; gate_alu = 1'b1; ld_reg = 1'b1; end
          OP_BR: begin
            pcmux_sel = 2'd1; a1m_sel = 1'b1; a2m_sel = 2'd1;
            ld_pc = |(ir[11:9] & nzp);
          end
          OP_JMP: begin
            pcmux_sel = 2'd1; a1m_sel = 1'b0; a2m_sel = 2'd3; ld_pc = 1'b1;
          end
          // R7 is written with PC at the same edge the PC takes the target, so JSRR
          // still reads the old R7 as its base.
          OP_JSR: begin
            gate_pc = 1'b1; ld_reg = 1'b1; ld_pc = 1'b1; pcmux_sel = 2'd1;
            a1m_sel = ~ir[11];
            a2m_sel = ir[11] ? 2'd0 : 2'd3;
            a1m_sel = ir[11];
          end
          OP_LEA: begin
            gate_marmux = 1'b1; marmux_sel = 1'b1; ld_reg = 1'b1;
            a1m_sel = 1'b1; a2m_sel = 2'd1;
          end
          default: ;
        endcase
      end
      S_ADDR: begin
        gate_marmux = 1'b1; marmux_sel = 1'b1; ld_mar = 1'b1;
        if (op == OP_LDR || op == OP_STR) begin
          a1m_sel = 1'b0; a2m_sel = 2'd2;
        end else begin
          a1m_sel = 1'b1; a2m_sel = 2'd1;
        end
      end
      S_RD1, S_RD2, S_TRAP_RD: begin
        mem_en = 1'b1;
        ld_mdr = (wcnt == DATA_LAST);
      end
      S_IND: begin
        gate_mdr = 1'b1; ld_mar = 1'b1;
      end
      S_WB: begin
        gate_mdr = 1'b1; ld_reg = 1'b1; instr_done = 1'b1;
      end
      S_SMDR: begin
        sr1 = ir[11:9]; aluk = 2'b00; gate_alu = 1'b1; mem_en = 1'b0; ld_mdr = 1'b1;
      end
      S_WR: begin
        mem_rw = 1'b1; instr_done = 1'b1;
      end
      S_TRAP1: begin
        gate_pc = 1'b1; ld_reg = 1'b1;
      end
      S_TRAP2: begin
        gate_marmux = 1'b1; marmux_sel = 1'b0; ld_mar = 1'b1;
      end
      S_TRAP3: begin
        gate_mdr = 1'b1; pcmux_sel = 2'd0; ld_pc = 1'b1; instr_done = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign cc_load = ld_reg && (op == OP_ADD || op == OP_AND || op == OP_NOT ||
                              op == OP_LD  || op == OP_LDR || op == OP_LDI);

endmodule

// File: tb/tb_lc3_control.sv
// Directed bench for lc3_control: one instance with MEM_WAIT=1 runs the instruction
// sequence, a second with MEM_WAIT=3 covers the stretched fetch read.
module tb_lc3_control;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic [15:0] ir, bus;

  logic d1_ld_ir, d1_ld_reg, d1_ld_pc, d1_ld_mar, d1_ld_mdr;
  logic [2:0] d1_dr, d1_sr1, d1_sr2, d1_nzp;
  logic [1:0] d1_aluk, d1_a2m_sel, d1_pcmux_sel;
  logic d1_a1m_sel, d1_marmux_sel, d1_mem_en, d1_mem_rw;
  logic d1_gate_alu, d1_gate_pc, d1_gate_marmux, d1_gate_mdr, d1_instr_done, d1_halted;

  logic d3_ld_ir, d3_ld_reg, d3_ld_pc, d3_ld_mar, d3_ld_mdr;
  logic [2:0] d3_dr, d3_sr1, d3_sr2, d3_nzp;
  logic [1:0] d3_aluk, d3_a2m_sel, d3_pcmux_sel;
  logic d3_a1m_sel, d3_marmux_sel, d3_mem_en, d3_mem_rw;
  logic d3_gate_alu, d3_gate_pc, d3_gate_marmux, d3_gate_mdr, d3_instr_done, d3_halted;

  logic [28:0] d1_ctl;
  assign d1_ctl = {d1_ld_ir, d1_ld_reg, d1_ld_pc, d1_ld_mar, d1_ld_mdr, d1_dr, d1_sr1, d1_sr2,
                   d1_aluk, d1_a1m_sel, d1_a2m_sel, d1_pcmux_sel, d1_marmux_sel, d1_mem_en,
                   d1_mem_rw, d1_gate_alu, d1_gate_pc, d1_gate_marmux, d1_gate_mdr, d1_instr_done};

  int checks = 0;
  int passed = 0;

  lc3_control #(.MEM_WAIT(1)) dut1 (
    .clk(clk), .rst(rst1), .ir(ir), .bus(bus),
    .ld_ir(d1_ld_ir), .ld_reg(d1_ld_reg), .ld_pc(d1_ld_pc), .ld_mar(d1_ld_mar), .ld_mdr(d1_ld_mdr),
    .dr(d1_dr), .sr1(d1_sr1), .sr2(d1_sr2), .aluk(d1_aluk), .a1m_sel(d1_a1m_sel),
    .a2m_sel(d1_a2m_sel), .pcmux_sel(d1_pcmux_sel), .marmux_sel(d1_marmux_sel),
    .mem_en(d1_mem_en), .mem_rw(d1_mem_rw), .gate_alu(d1_gate_alu), .gate_pc(d1_gate_pc),
    .gate_marmux(d1_gate_marmux), .gate_mdr(d1_gate_mdr), .nzp(d1_nzp),
    .instr_done(d1_instr_done), .halted(d1_halted)
  );

  lc3_control #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .rst(rst3), .ir(ir), .bus(bus),
    .ld_ir(d3_ld_ir), .ld_reg(d3_ld_reg), .ld_pc(d3_ld_pc), .ld_mar(d3_ld_mar), .ld_mdr(d3_ld_mdr),
    .dr(d3_dr), .sr1(d3_sr1), .sr2(d3_sr2), .aluk(d3_aluk), .a1m_sel(d3_a1m_sel),
    .a2m_sel(d3_a2m_sel), .pcmux_sel(d3_pcmux_sel), .marmux_sel(d3_marmux_sel),
    .mem_en(d3_mem_en), .mem_rw(d3_mem_rw), .gate_alu(d3_gate_alu), .gate_pc(d3_gate_pc),
    .gate_marmux(d3_gate_marmux), .gate_mdr(d3_gate_mdr), .nzp(d3_nzp),
    .instr_done(d3_instr_done), .halted(d3_halted)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ir = 16'h1261; bus = 16'h0000; rst1 = 1'b1; rst3 = 1'b1;
    tick(2);
    rst1 = 1'b0; rst3 = 1'b0;

    // T1: both in FETCH1 straight out of reset
    chk("rst_fetch1_ctl", 32'({d1_gate_pc, d1_ld_mar, d1_ld_pc}), 32'b111);
    chk("rst_pcmux", 32'(d1_pcmux_sel), 2);
    chk("rst_nzp", 32'(d1_nzp), 32'b010);
    chk("rst_done_halt", 32'({d1_instr_done, d1_halted, d1_mem_en, d1_ld_reg}), 0);
    chk("w3_fetch1", 32'(d3_gate_pc), 1);

    // T2: FETCH2; W=1 reads in one cycle, W=3 is on its first of three
    tick(1);
    chk("w1_fetch2_ldmdr", 32'({d1_mem_en, d1_ld_mdr}), 32'b11);
    chk("w3_fetch2_c1", 32'({d3_mem_en, d3_ld_mdr}), 32'b10);
    rst1 = 1'b1;
    tick(1);
    rst1 = 1'b0;

    // T3: dut1 reset mid-FETCH2 lands back in FETCH1
    chk("midrst_fetch1", 32'({d1_gate_pc, d1_ld_mar, d1_ld_pc}), 32'b111);
    chk("midrst_no_ldmdr", 32'(d1_ld_mdr), 0);
    chk("midrst_nzp", 32'(d1_nzp), 32'b010);
    chk("w3_fetch2_c2", 32'({d3_mem_en, d3_ld_mdr}), 32'b10);

    tick(1); // T4
    chk("w3_fetch2_c3", 32'({d3_mem_en, d3_ld_mdr}), 32'b11);
    tick(1); // T5: dut1 FETCH3, dut3 FETCH3
    chk("w1_fetch3", 32'({d1_gate_mdr, d1_ld_ir}), 32'b11);
    chk("w3_fetch3", 32'({d3_gate_mdr, d3_ld_ir}), 32'b11);
    tick(1); // T6: DECODE
    chk("add_decode_not_done", 32'(d1_instr_done), 0);
    bus = 16'hFFFF;
    tick(1); // T7: dut1 ADD EXEC at cycle 5; dut3 ALU done at 4+3=7
    chk("add_ldreg_gate", 32'({d1_ld_reg, d1_gate_alu}), 32'b11);
    chk("add_dr", 32'(d1_dr), 1);
    chk("add_aluk", 32'(d1_aluk), 32'b10);
    chk("add_done_c5", 32'(d1_instr_done), 1);
    chk("w3_add_done_c7", 32'(d3_instr_done), 1);
    tick(1);
    chk("add_nzp_neg", 32'(d1_nzp), 32'b100);

    // BRz taken with nzp=010 (fresh reset)
    rst1 = 1'b1; ir = 16'h0402;
    tick(1);
    rst1 = 1'b0;
    tick(3);
    chk("brz_c4_not_done", 32'(d1_instr_done), 0);
    tick(1);
    chk("brz_taken_ldpc", 32'({d1_ld_pc, d1_pcmux_sel}), 32'b101);
    chk("brz_taken_done", 32'(d1_instr_done), 1);

    // ADD with positive result sets nzp=001
    tick(1);
    ir = 16'h1261; bus = 16'h0001;
    tick(4);
    tick(1);
    chk("add_nzp_pos", 32'(d1_nzp), 32'b001);

    // BRz not taken with nzp=001
    ir = 16'h0402;
    tick(4);
    chk("brz_not_taken", 32'({d1_ld_pc, d1_instr_done}), 32'b01);

    // STR R0,R1,#2
    tick(1);
    ir = 16'h7042;
    tick(4);
    chk("str_addr", 32'({d1_ld_mar, d1_gate_marmux, d1_marmux_sel, d1_ld_mdr}), 32'b1110);
    chk("str_addr_sel", 32'({d1_a1m_sel, d1_a2m_sel, d1_sr1}), 32'b0_10_001);
    tick(1);
    chk("str_mdr", 32'({d1_ld_mdr, d1_mem_en, d1_gate_alu, d1_aluk, d1_mem_rw}), 32'b101000);
    chk("str_sr1", 32'(d1_sr1), 0);
    tick(1);
    chk("str_wr_c7", 32'({d1_mem_rw, d1_instr_done}), 32'b11);
    tick(1);
    chk("str_single_rw", 32'(d1_mem_rw), 0);
    chk("str_nzp_kept", 32'(d1_nzp), 32'b001);

    // TRAP x25
    ir = 16'hF025;
    tick(4);
    chk("trap_r7", 32'({d1_ld_reg, d1_gate_pc, d1_dr}), 32'b11_111);
    tick(1);
    chk("trap_mar_zext", 32'({d1_ld_mar, d1_gate_marmux, d1_marmux_sel, d1_ld_reg}), 32'b1100);
    tick(1);
    chk("trap_rd_c1", 32'({d1_mem_en, d1_ld_mdr}), 32'b10);
    tick(1);
    chk("trap_rd_c2", 32'({d1_mem_en, d1_ld_mdr}), 32'b11);
    tick(1);
    chk("trap_pc_c9", 32'({d1_gate_mdr, d1_ld_pc, d1_pcmux_sel, d1_instr_done}), 32'b11_00_1);
    tick(1);
    chk("trap_nzp_kept", 32'(d1_nzp), 32'b001);

    // LD R5 with zero data: 6+2W = 8 cycles, nzp -> 010
    ir = 16'h2A05; bus = 16'h0000;
    tick(4);
    chk("ld_addr", 32'({d1_ld_mar, d1_a1m_sel, d1_a2m_sel}), 32'b1_1_01);
    tick(2);
    chk("ld_rd_last", 32'(d1_ld_mdr), 1);
    tick(1);
    chk("ld_wb_c8", 32'({d1_ld_reg, d1_gate_mdr, d1_dr, d1_instr_done}), 32'b11_101_1);
    tick(1);
    chk("ld_nzp_zero", 32'(d1_nzp), 32'b010);

    // Reserved opcode halts after DECODE and stays halted until reset
    ir = 16'hD000;
    tick(3);
    chk("halt_decode", 32'(d1_halted), 0);
    tick(1);
    chk("halt_set", 32'(d1_halted), 1);
    chk("halt_outputs_zero", 32'(d1_ctl), 0);
    tick(3);
    chk("halt_held", 32'({d1_halted, d1_ctl}), 32'h2000_0000);
    rst1 = 1'b1;
    tick(1);
    rst1 = 1'b0;
    chk("halt_rst_fetch1", 32'({d1_halted, d1_gate_pc, d1_ld_pc}), 32'b011);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule
